// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 opcode encodings, NOP word and fetch FSM state type.
//   Imported by imm_gen and inst_fetch_unit.
package rv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: req/ack instruction memory port.
//   imem_req   request, held until ack (or timeout)
//   imem_addr  fetch address, stable while imem_req=1
//   imem_rdata instruction word, valid with imem_ack
//   imem_ack   one-cycle data-valid strobe
//   master = fetch unit side, slave = memory side.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/inst_fetch_unit_imm_gen.sv
// imm_gen: combinational sign-extended immediate from an RV32 instruction word.
//   ir  in  32  instruction
//   imm out 32  I/S/B/U/J immediate by opcode, 0 for any other opcode
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);
    logic [6:0]  op;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign op    = ir[6:0];
    assign i_imm = {{20{ir[31]}}, ir[31:20]};
    assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm = {ir[31:12], 12'b0};
    assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        imm = (op == OP_IMM || op == LOAD || op == JALR) ? i_imm :
              (op == STORE)                              ? s_imm :
              (op == BRANCH)                             ? b_imm :
              (op == LUI || op == AUIPC)                 ? u_imm :
              (op == JAL)                                ? j_imm : 32'b0;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle fetch stage owning PC and IR, with decoded IR fields.
//   clk, rst            clock, synchronous active-high reset
//   fetch_req           start a fetch at pc (sampled in IDLE only)
//   pc_ld, pc_ld_val    PC load, wins over the +4 increment, any state
//   imem                inst_fetch_unit_if.master memory port
//   ir, opcode, funct3, funct7, rs1, rs2, rd, imm   instruction and decoded fields
//   pc                  next fetch address
//   pc_cur              address of the instruction held in ir
//   fetch_busy          high in BUSY
//   fetch_done          one-cycle pulse in DONE
//   fetch_err           sticky watchdog timeout flag
// Optional feature macro: FETCH_TIMEOUT_EN enables the BUSY watchdog (TIMEOUT_CYC);
// without it BUSY waits indefinitely and fetch_err is tied low.
module inst_fetch_unit
    import rv_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYC = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_ld_val,
    inst_fetch_unit_if.master imem,
    output logic [31:0]       ir,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [31:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_cur,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);
    fetch_state_t state_q, state_d;
    logic start, accept, timeout;

    assign start      = (state_q == ST_IDLE) && fetch_req;
    assign accept     = (state_q == ST_BUSY) && imem.imem_ack;
    assign fetch_busy = (state_q == ST_BUSY);
    assign fetch_done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = fetch_req ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_d = (imem.imem_ack || timeout) ? ST_DONE : ST_BUSY;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // imem_addr is only written on start, so a pc_ld while BUSY redirects
    // the next fetch without disturbing the request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            pc_cur         <= RESET_PC;
            imem.imem_addr <= RESET_PC;
            imem.imem_req  <= 1'b0;
            ir             <= NOP;
        end else begin
            if (start) begin
                imem.imem_addr <= pc_ld ? pc_ld_val : pc;
                imem.imem_req  <= 1'b1;
            end
            if (accept || timeout) imem.imem_req <= 1'b0;
            if (accept) begin
                ir     <= imem.imem_rdata;
                pc_cur <= imem.imem_addr;
            end
            pc <= pc_ld ? pc_ld_val : accept ? imem.imem_addr + ADDR_W'(4) : pc;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;

    // Fires on the TIMEOUT_CYC-th BUSY cycle without an ack.
    assign timeout = (state_q == ST_BUSY) && !imem.imem_ack && (wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd        <= '0;
            fetch_err <= 1'b0;
        end else begin
            wd        <= (state_q == ST_BUSY && !timeout) ? wd + 1'b1 : '0;
            fetch_err <= timeout ? 1'b1 : start ? 1'b0 : fetch_err;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];

    imm_gen u_imm_gen (
        .ir  (ir),
        .imm (imm)
    );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed self-checking bench for inst_fetch_unit.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, fetch_req, pc_ld;
    logic [31:0] pc_ld_val;
    logic [31:0] ir, imm, pc, pc_cur;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        fetch_busy, fetch_done, fetch_err;
    int          total = 0;
    int          bad = 0;

    inst_fetch_unit_if #(.ADDR_W(32)) imem ();

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc_ld      (pc_ld),
        .pc_ld_val  (pc_ld_val),
        .imem       (imem.master),
        .ir         (ir),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .imm        (imm),
        .pc         (pc),
        .pc_cur     (pc_cur),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from IDLE: optional pc_ld at start or at the ack cycle, dly BUSY cycles before ack.
    task automatic do_fetch(input logic [31:0] data, input int dly, input logic idle_ld,
                            input logic ack_ld, input logic [31:0] ldv, input logic [31:0] exp_addr);
        fetch_req = 1'b1;
        pc_ld     = idle_ld;
        pc_ld_val = ldv;
        tick();
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        check("busy", {31'b0, fetch_busy}, 32'd1);
        check("req", {31'b0, imem.imem_req}, 32'd1);
        check("addr", imem.imem_addr, exp_addr);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("wait_req", {31'b0, imem.imem_req}, 32'd1);
            check("wait_addr", imem.imem_addr, exp_addr);
            check("wait_done", {31'b0, fetch_done}, 32'd0);
        end
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = data;
        pc_ld           = ack_ld;
        pc_ld_val       = ldv;
        tick();
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'hDEAD_BEEF;
        pc_ld           = 1'b0;
        check("done", {31'b0, fetch_done}, 32'd1);
        check("req_drop", {31'b0, imem.imem_req}, 32'd0);
        check("ir", ir, data);
        check("pc_cur", pc_cur, exp_addr);
        tick();
        check("done_pulse", {31'b0, fetch_done}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        fetch_req       = 1'b0;
        pc_ld           = 1'b0;
        pc_ld_val       = '0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        repeat (2) tick();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_cur", pc_cur, 32'h0);
        check("rst_addr", imem.imem_addr, 32'h0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_req", {31'b0, imem.imem_req}, 32'd0);
        check("rst_flags", {29'b0, fetch_busy, fetch_done, fetch_err}, 32'd0);
        rst = 1'b0;

        do_fetch(32'h0050_0093, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("addi_op", {25'b0, opcode}, 32'h13);
        check("addi_rd", {27'b0, rd}, 32'd1);
        check("addi_imm", imm, 32'd5);
        check("addi_pc", pc, 32'h4);

        do_fetch(32'h1234_5037, 5, 1'b0, 1'b0, 32'h0, 32'h4);
        check("lui_imm", imm, 32'h1234_5000);
        check("lui_pc", pc, 32'h8);

        do_fetch(32'hFE11_2E23, 0, 1'b0, 1'b1, 32'h100, 32'h8);
        check("sw_imm", imm, 32'hFFFF_FFFC);
        check("ackld_pc", pc, 32'h100);

        do_fetch(32'hFFDF_F06F, 0, 1'b1, 1'b0, 32'h200, 32'h200);
        check("jal_imm", imm, 32'hFFFF_FFFC);
        check("idleld_pc", pc, 32'h204);

        do_fetch(32'h0020_9463, 2, 1'b0, 1'b0, 32'h0, 32'h204);
        check("bne_imm", imm, 32'd8);
        check("bne_f3", {29'b0, funct3}, 32'd1);
        check("bne_rs", {22'b0, rs1, rs2}, {22'b0, 5'd1, 5'd2});
        check("bne_pc", pc, 32'h208);

        do_fetch(32'h0020_81B3, 0, 1'b0, 1'b0, 32'h0, 32'h208);
        check("add_imm", imm, 32'h0);
        check("add_f7", {25'b0, funct7}, 32'h0);
        check("add_rd", {27'b0, rd}, 32'd3);

        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h0000_0BAD;
        tick();
        imem.imem_ack   = 1'b0;
        check("idle_ack_ir", ir, 32'h0020_81B3);
        check("idle_ack_pc", pc, 32'h20C);
        check("idle_ack_busy", {31'b0, fetch_busy}, 32'd0);

        pc_ld     = 1'b1;
        pc_ld_val = 32'hFFFF_FFFC;
        tick();
        pc_ld = 1'b0;
        check("ld_pc", pc, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0013, 0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'h0);

        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check("pre_to_busy", {31'b0, fetch_busy}, 32'd1);
        tick();
        check("to_done", {31'b0, fetch_done}, 32'd1);
        check("to_err", {31'b0, fetch_err}, 32'd1);
        check("to_req", {31'b0, imem.imem_req}, 32'd0);
        check("to_ir", ir, 32'h0000_0013);
        check("to_pc", pc, 32'h0);
        tick();
        check("to_err_hold", {31'b0, fetch_err}, 32'd1);
        do_fetch(32'h0050_0093, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("err_clr", {31'b0, fetch_err}, 32'd0);
`else
        repeat (20) tick();
        check("nto_busy", {31'b0, fetch_busy}, 32'd1);
        check("nto_req", {31'b0, imem.imem_req}, 32'd1);
        check("nto_err", {31'b0, fetch_err}, 32'd0);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h0050_0093;
        tick();
        imem.imem_ack = 1'b0;
        check("nto_done", {31'b0, fetch_done}, 32'd1);
        tick();
`endif
        check("pre_rst_pc", pc, 32'h4);

        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("mid_busy", {31'b0, fetch_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req", {31'b0, imem.imem_req}, 32'd0);
        check("mid_rst_ir", ir, 32'h0000_0013);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_pc_cur", pc_cur, 32'h0);
        check("mid_rst_addr", imem.imem_addr, 32'h0);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h1234_5037;
        tick();
        imem.imem_ack = 1'b0;
        check("late_ack_ir", ir, 32'h0000_0013);
        check("late_ack_flags", {30'b0, fetch_busy, fetch_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
